// File: rtl/inst_issue_queue_if.sv
// inst_issue_queue_if: host-to-queue instruction handshake (valid/ready).
// The host drives inst_in/inst_valid; the queue answers with inst_ready.
interface inst_issue_queue_if #(
  parameter int INST_BITS = 16
);
  logic [INST_BITS-1:0] inst_in;
  logic                 inst_valid;
  logic                 inst_ready;

  modport master (
    output inst_in,
    output inst_valid,
    input  inst_ready
  );

  modport slave (
    input  inst_in,
    input  inst_valid,
    output inst_ready
  );
endinterface

// File: rtl/inst_issue_queue.sv
// inst_issue_queue: DEPTH-entry instruction FIFO plus a one-deep issue stage
// feeding the systolic-array control unit. The staged instruction advances
// only on CU take edges (cu_flag high); IDLE bubbles are staged when the
// queue is empty, when halted, or when the settle interlock blocks a matmul.
// Optional build macro: ISSUE_HAZARD_EN enables the LOAD_WEIGHT -> MAT_MUL /
// MAT_MUL_ACC settle interlock (SETTLE state and settle counter).
module inst_issue_queue #(
  parameter int INST_BITS     = 16,
  parameter int OPCODE_BITS   = 4,
  parameter int DEPTH         = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  inst_issue_queue_if.slave        host,
  input  logic                     halt,
  input  logic                     cu_flag,
  output logic [INST_BITS-1:0]     cu_instruction,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy,
  output logic [15:0]              issued_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Elaboration-time parameter sanity checks
  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("inst_issue_queue: DEPTH must be a power of two and at least 2");
    end
    if (OPCODE_BITS < 1 || OPCODE_BITS > INST_BITS) begin : g_bad_opcode
      $error("inst_issue_queue: OPCODE_BITS must lie in 1..INST_BITS");
    end
    if (SETTLE_CYCLES < 0 || SETTLE_CYCLES > 255) begin : g_bad_settle
      $error("inst_issue_queue: SETTLE_CYCLES must lie in 0..255");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HALT   = 2'd2
  } state_t;

  // FIFO storage and pointers
  logic [INST_BITS-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;

  // Issue stage and scheduler state
  state_t               state_q, state_d;
  logic [INST_BITS-1:0] stage_q, stage_d;
  logic                 staged_valid_q, staged_valid_d;
  logic [15:0]          issued_q, issued_d;

  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic                 take;
  logic [INST_BITS-1:0] head;
  logic                 head_eligible;
  logic                 settling;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = host.inst_valid && !full;
  assign take  = cu_flag;
  assign head  = mem_q[rd_ptr_q];

`ifdef ISSUE_HAZARD_EN
  localparam logic [OPCODE_BITS-1:0] LOAD_WEIGHT_INST = OPCODE_BITS'(2);
  localparam logic [OPCODE_BITS-1:0] MAT_MUL_INST     = OPCODE_BITS'(3);
  localparam logic [OPCODE_BITS-1:0] MAT_MUL_ACC_INST = OPCODE_BITS'(4);

  logic [7:0]             settle_cnt_q, settle_cnt_d;
  logic [OPCODE_BITS-1:0] head_op;
  logic [OPCODE_BITS-1:0] staged_op;
  logic                   lw_take;

  assign head_op   = head[INST_BITS-1 -: OPCODE_BITS];
  assign staged_op = stage_q[INST_BITS-1 -: OPCODE_BITS];
  assign lw_take   = take && staged_valid_q && (staged_op == LOAD_WEIGHT_INST);

  // Settle counter: reload on a LOAD_WEIGHT take, otherwise count down to 0
  always_comb begin
    settle_cnt_d = settle_cnt_q;
    if (lw_take && (SETTLE_CYCLES != 0)) begin
      settle_cnt_d = 8'(SETTLE_CYCLES);
    end else if (settle_cnt_q != 8'd0) begin
      settle_cnt_d = settle_cnt_q - 8'd1;
    end
  end

  // A matmul head may be staged only once the counter has expired after this
  // edge, which puts its take SETTLE_CYCLES+1 edges after the LOAD_WEIGHT take.
  assign settling      = (settle_cnt_d != 8'd0);
  assign head_eligible = !((head_op == MAT_MUL_INST) || (head_op == MAT_MUL_ACC_INST))
                         || !settling;

  // Settle counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      settle_cnt_q <= 8'd0;
    end else begin
      settle_cnt_q <= settle_cnt_d;
    end
  end
`else
  assign settling      = 1'b0;
  assign head_eligible = 1'b1;
`endif

  // Scheduler: choose the next staged instruction and FSM state at each take
  always_comb begin
    state_d        = state_q;
    stage_d        = stage_q;
    staged_valid_d = staged_valid_q;
    issued_d       = issued_q;
    pop            = 1'b0;
    if (take) begin
      if (staged_valid_q) begin
        issued_d = issued_q + 16'd1;
      end
      if (halt) begin
        stage_d        = '0;
        staged_valid_d = 1'b0;
        state_d        = ST_HALT;
      end else begin
        state_d = settling ? ST_SETTLE : ST_RUN;
        if (!empty && head_eligible) begin
          stage_d        = head;
          staged_valid_d = 1'b1;
          pop            = 1'b1;
        end else begin
          stage_d        = '0;
          staged_valid_d = 1'b0;
        end
      end
    end else if (state_q == ST_SETTLE && !settling) begin
      state_d = ST_RUN;
    end
  end

  // FIFO pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // FIFO storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= host.inst_in;
    end
  end

  // Control and issue registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      state_q        <= ST_RUN;
      stage_q        <= '0;
      staged_valid_q <= 1'b0;
      issued_q       <= 16'd0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      state_q        <= state_d;
      stage_q        <= stage_d;
      staged_valid_q <= staged_valid_d;
      issued_q       <= issued_d;
    end
  end

  assign host.inst_ready = !full;
  assign cu_instruction  = stage_q;
  assign fifo_count      = count_q;
  assign busy            = !empty || staged_valid_q;
  assign issued_cnt      = issued_q;

endmodule

// File: tb/tb_inst_issue_queue.sv
// tb_inst_issue_queue: table vectors, directed corner sequences and a
// randomized run compared against a queue-based reference model.
`timescale 1ns/1ps
module tb_inst_issue_queue;
  localparam int INST_BITS     = 16;
  localparam int OPCODE_BITS   = 4;
  localparam int DEPTH         = 8;
  localparam int SETTLE_CYCLES = 4;
  localparam logic [3:0] OP_LW  = 4'h2;
  localparam logic [3:0] OP_MM  = 4'h3;
  localparam logic [3:0] OP_MMA = 4'h4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        halt = 1'b0;
  logic        cu_flag = 1'b0;
  logic [15:0] cu_instruction;
  logic [3:0]  fifo_count;
  logic        busy;
  logic [15:0] issued_cnt;

  inst_issue_queue_if #(.INST_BITS(INST_BITS)) host_if ();

  inst_issue_queue #(
    .INST_BITS(INST_BITS), .OPCODE_BITS(OPCODE_BITS),
    .DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .clk(clk), .reset_n(reset_n), .host(host_if), .halt(halt),
    .cu_flag(cu_flag), .cu_instruction(cu_instruction),
    .fifo_count(fifo_count), .busy(busy), .issued_cnt(issued_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [15:0] mq[$];
  logic [15:0] m_stage;
  bit          m_valid;
  logic [15:0] m_issued;
  int          edge_no;
  int          lw_edge;
  int          n_checks = 0;
  int          n_pass = 0;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        f;
    logic        h;
    logic [15:0] e_cu;
    int          e_cnt;
    logic        e_rdy;
    logic        e_busy;
    logic [15:0] e_iss;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_no);
  endtask

  // Model of one rising edge from the current inputs
  task automatic model_edge();
    bit          push_now;
    bit          can_issue;
    logic [15:0] hd;
    push_now = host_if.inst_valid && (mq.size() < DEPTH);
    if (cu_flag) begin
      if (m_valid) m_issued = m_issued + 16'd1;
`ifdef ISSUE_HAZARD_EN
      if (m_valid && m_stage[15:12] == OP_LW && SETTLE_CYCLES > 0) lw_edge = edge_no;
`endif
      if (halt) begin
        m_stage = 16'h0;
        m_valid = 0;
      end else begin
        can_issue = (mq.size() > 0);
`ifdef ISSUE_HAZARD_EN
        if (can_issue) begin
          hd = mq[0];
          if ((hd[15:12] == OP_MM || hd[15:12] == OP_MMA) && edge_no < lw_edge + SETTLE_CYCLES)
            can_issue = 0;
        end
`endif
        if (can_issue) begin
          m_stage = mq.pop_front();
          m_valid = 1;
        end else begin
          m_stage = 16'h0;
          m_valid = 0;
        end
      end
    end
    if (push_now) mq.push_back(host_if.inst_in);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    edge_no++;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".cu"}, 32'(cu_instruction), 32'(m_stage));
    chk({tag, ".count"}, 32'(fifo_count), 32'(mq.size()));
    chk({tag, ".ready"}, 32'(host_if.inst_ready), 32'(mq.size() < DEPTH));
    chk({tag, ".busy"}, 32'(busy), 32'((mq.size() != 0) || m_valid));
    chk({tag, ".issued"}, 32'(issued_cnt), 32'(m_issued));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    host_if.inst_valid = 1'b0;
    host_if.inst_in = 16'h0;
    cu_flag = 1'b0;
    halt = 1'b0;
    mq.delete();
    m_stage = 16'h0;
    m_valid = 0;
    m_issued = 16'h0;
    lw_edge = -1000;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_h[8];
    logic [3:0]  ops[7];
    int          guard;
    int          flag_pct;
    logic [3:0]  op;

    edge_no = 0;
    host_if.inst_valid = 1'b0;
    host_if.inst_in = 16'h0;
    #2;
    do_reset();
    chk("reset.cu", 32'(cu_instruction), 32'h0);
    chk("reset.count", 32'(fifo_count), 32'd0);
    chk("reset.ready", 32'(host_if.inst_ready), 32'd1);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.issued", 32'(issued_cnt), 32'd0);

    // Table: 3-word latency, hold without flag, halt bubble and resume
    tbl[0] = '{1'b1, 16'h5A01, 1'b1, 1'b0, 16'h0000, 1, 1'b1, 1'b1, 16'd0};
    tbl[1] = '{1'b1, 16'h5B02, 1'b1, 1'b0, 16'h5A01, 1, 1'b1, 1'b1, 16'd0};
    tbl[2] = '{1'b1, 16'h5C03, 1'b1, 1'b0, 16'h5B02, 1, 1'b1, 1'b1, 16'd1};
    tbl[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h5C03, 0, 1'b1, 1'b1, 16'd2};
    tbl[4] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 0, 1'b1, 1'b0, 16'd3};
    tbl[5] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 0, 1'b1, 1'b0, 16'd3};
    tbl[6] = '{1'b1, 16'h5D04, 1'b0, 1'b0, 16'h0000, 1, 1'b1, 1'b1, 16'd3};
    tbl[7] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 1, 1'b1, 1'b1, 16'd3};
    tbl[8] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h5D04, 0, 1'b1, 1'b1, 16'd3};
    tbl[9] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 0, 1'b1, 1'b0, 16'd4};
    for (int i = 0; i < 10; i++) begin
      host_if.inst_valid = tbl[i].v;
      host_if.inst_in = tbl[i].d;
      cu_flag = tbl[i].f;
      halt = tbl[i].h;
      tick();
      chk($sformatf("tbl%0d.cu", i), 32'(cu_instruction), 32'(tbl[i].e_cu));
      chk($sformatf("tbl%0d.count", i), 32'(fifo_count), 32'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d.ready", i), 32'(host_if.inst_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d.busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d.issued", i), 32'(issued_cnt), 32'(tbl[i].e_iss));
    end
    halt = 1'b0;

    // Fill to full with no takes, reject a 9th word, then drain in order
    do_reset();
    for (int i = 0; i < 8; i++) begin
      host_if.inst_valid = 1'b1;
      host_if.inst_in = 16'h5100 + 16'(i);
      tick();
    end
    chk("full.count", 32'(fifo_count), 32'd8);
    chk("full.ready", 32'(host_if.inst_ready), 32'd0);
    host_if.inst_in = 16'h5EEE;
    tick();
    chk("full.ninth_count", 32'(fifo_count), 32'd8);
    host_if.inst_valid = 1'b0;
    cu_flag = 1'b1;
    tick();
    chk("drain.first_cu", 32'(cu_instruction), 32'h5100);
    chk("drain.first_ready", 32'(host_if.inst_ready), 32'd1);
    chk("drain.first_count", 32'(fifo_count), 32'd7);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("drain%0d.cu", i), 32'(cu_instruction), 32'h5100 + 32'(i));
    end
    tick();
    chk("drain.end_cu", 32'(cu_instruction), 32'h0);
    chk("drain.end_issued", 32'(issued_cnt), 32'd8);
    check_model("drain");

    // Settle interlock: LOAD_WEIGHT, MAT_MUL, WRITE_DATA
    do_reset();
    host_if.inst_valid = 1'b1;
    host_if.inst_in = 16'h2001; tick();
    host_if.inst_in = 16'h3002; tick();
    host_if.inst_in = 16'h5003; tick();
    host_if.inst_valid = 1'b0;
    cu_flag = 1'b1;
    for (int i = 0; i < 8; i++) exp_h[i] = 16'h0;
`ifdef ISSUE_HAZARD_EN
    exp_h[0] = 16'h2001; exp_h[5] = 16'h3002; exp_h[6] = 16'h5003;
`else
    exp_h[0] = 16'h2001; exp_h[1] = 16'h3002; exp_h[2] = 16'h5003;
`endif
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("settle%0d.cu", i), 32'(cu_instruction), 32'(exp_h[i]));
    end
    check_model("settle");

    // Halt with 4 queued, then resume
    do_reset();
    for (int i = 0; i < 4; i++) begin
      host_if.inst_valid = 1'b1;
      host_if.inst_in = 16'h1100 + 16'(i);
      tick();
    end
    host_if.inst_valid = 1'b0;
    halt = 1'b1;
    cu_flag = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("halt%0d.cu", i), 32'(cu_instruction), 32'h0);
      chk($sformatf("halt%0d.count", i), 32'(fifo_count), 32'd4);
    end
    halt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("resume%0d.cu", i), 32'(cu_instruction), 32'h1100 + 32'(i));
    end
    tick();
    chk("resume.end_cu", 32'(cu_instruction), 32'h0);
    chk("resume.issued", 32'(issued_cnt), 32'd4);
    chk("resume.count", 32'(fifo_count), 32'd0);

    // Reset mid-stream with a staged word and 5 queued
    do_reset();
    cu_flag = 1'b1;
    host_if.inst_valid = 1'b1;
    host_if.inst_in = 16'h6001; tick();
    host_if.inst_in = 16'h6002; tick();
    host_if.inst_valid = 1'b0;
    tick(); tick();
    cu_flag = 1'b0;
    for (int i = 0; i < 6; i++) begin
      host_if.inst_valid = 1'b1;
      host_if.inst_in = 16'h6100 + 16'(i);
      tick();
    end
    host_if.inst_valid = 1'b0;
    cu_flag = 1'b1;
    tick();
    chk("midrst.pre_count", 32'(fifo_count), 32'd5);
    chk("midrst.pre_cu", 32'(cu_instruction), 32'h6100);
    chk("midrst.pre_issued", 32'(issued_cnt), 32'd2);
    do_reset();
    chk("midrst.count", 32'(fifo_count), 32'd0);
    chk("midrst.cu", 32'(cu_instruction), 32'h0);
    chk("midrst.issued", 32'(issued_cnt), 32'd0);
    chk("midrst.busy", 32'(busy), 32'd0);
    cu_flag = 1'b1;
    host_if.inst_valid = 1'b1;
    host_if.inst_in = 16'h7007;
    tick();
    host_if.inst_valid = 1'b0;
    tick();
    chk("midrst.after_cu", 32'(cu_instruction), 32'h7007);
    check_model("midrst");

    // Randomized traffic against the reference model
    do_reset();
    ops[0] = 4'h0; ops[1] = 4'h1; ops[2] = OP_LW; ops[3] = OP_MM;
    ops[4] = OP_MMA; ops[5] = 4'h5; ops[6] = 4'h0;
    for (int i = 0; i < 800; i++) begin
      flag_pct = ((i / 100) % 2 == 1) ? 30 : 80;
      ops[6] = 4'($urandom_range(0, 15));
      op = ops[$urandom_range(0, 6)];
      host_if.inst_valid = ($urandom_range(0, 9) < 7);
      host_if.inst_in = {op, 12'($urandom)};
      cu_flag = ($urandom_range(0, 99) < flag_pct);
      halt = ($urandom_range(0, 9) == 0);
      tick();
      check_model($sformatf("rnd%0d", i));
    end
    halt = 1'b0;

    // issued_cnt wrap: 65535 issues, then two more
    do_reset();
    cu_flag = 1'b1;
    host_if.inst_valid = 1'b1;
    host_if.inst_in = 16'h5055;
    guard = 0;
    while (m_issued != 16'hFFFF && guard < 70000) begin
      tick();
      guard++;
    end
    chk("wrap.preload", 32'(issued_cnt), 32'hFFFF);
    host_if.inst_valid = 1'b0;
    tick();
    tick();
    chk("wrap.final", 32'(issued_cnt), 32'h0001);
    check_model("wrap");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
